// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and a multi-cycle memory.
// The controller is the master; it holds a request until ack or timeout.
interface dmem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer: one access at a time over req/ack, with byte-lane
// steering, load extension, misalignment reporting and an ack timeout.
module dmem_access_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic        bus_err,
    dmem_access_ctrl_if.master mem
);
    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [3:0]    op_q;      // op[3]=store, op[2]=unsigned, op[1:0]=size
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [WW-1:0] wait_q;
    logic          berr_q;
    logic [31:0]   rdata_q;

    logic is_acc, mis, accept, wait_hit;
    logic [31:0] ld_ext;
    logic [3:0]  st_be;
    logic [31:0] st_wd;

    // Size lives in op[1:0] for both loads and stores: 00 byte, 01 half, 11 word.
    always_comb begin
        is_acc = 1'b0;
        case (op)
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
            6'b101000, 6'b101001, 6'b101011: is_acc = 1'b1;
            default:                         is_acc = 1'b0;
        endcase
        mis = ((op[1:0] == 2'b01) && addr[0]) || ((op[1:0] == 2'b11) && (addr[1:0] != 2'b00));
    end

    assign accept   = (state == IDLE) && req_valid && is_acc && !mis;
    assign wait_hit = (wait_q == WW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        addr_err = 1'b0;
        case (state)
            IDLE: if (req_valid && is_acc) begin
                if (mis) addr_err = 1'b1;
                else begin
                    stall    = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem.mem_ack || wait_hit) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        case (addr_q[1:0])
            2'b00:   b = mem.mem_rdata[7:0];
            2'b01:   b = mem.mem_rdata[15:8];
            2'b10:   b = mem.mem_rdata[23:16];
            default: b = mem.mem_rdata[31:24];
        endcase
        h = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (op_q[1:0])
            2'b00:   ld_ext = op_q[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   ld_ext = op_q[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        st_be = 4'b1111;
        st_wd = wdata_q;
        if (op_q[3]) begin
            case (op_q[1:0])
                2'b00: begin
                    st_be = 4'b0001 << addr_q[1:0];
                    st_wd = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    st_be = addr_q[1] ? 4'b1100 : 4'b0011;
                    st_wd = {2{wdata_q[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            berr_q  <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            op_q    <= op[3:0];
            addr_q  <= addr;
            wdata_q <= wdata;
            wait_q  <= '0;
        end else if (state == BUSY) begin
            // Ack wins over a timeout landing in the same cycle.
            if (mem.mem_ack) begin
                rdata_q <= op_q[3] ? 32'b0 : ld_ext;
                berr_q  <= 1'b0;
            end else if (wait_hit) begin
                rdata_q <= '0;
                berr_q  <= 1'b1;
            end else begin
                wait_q  <= wait_q + WW'(1);
            end
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = (state == DONE);
    assign bus_err     = (state == DONE) && berr_q;

    assign mem.mem_req   = (state == BUSY);
    assign mem.mem_we    = (state == BUSY) && op_q[3];
    assign mem.mem_addr  = (state == BUSY) ? {addr_q[31:2], 2'b00} : 32'b0;
    assign mem.mem_be    = (state == BUSY) ? st_be : 4'b0;
    assign mem.mem_wdata = (state == BUSY) ? st_wd : 32'b0;
endmodule
